// File: rtl/soc_tcdm_bank_arbiter_if.sv
// Bus bundle for soc_tcdm_bank_arbiter: NR_MASTERS TCDM requesters plus one shared TCDM slave port.
// Modport slave is the arbiter's view; modport master is the surrounding masters and memory driving it.
interface soc_tcdm_bank_arbiter_if #(
    parameter int unsigned NR_MASTERS = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    // Requester side
    logic [NR_MASTERS-1:0]                 mst_req;
    logic [NR_MASTERS-1:0][ADDR_WIDTH-1:0] mst_add;
    logic [NR_MASTERS-1:0]                 mst_wen;
    logic [NR_MASTERS-1:0][DATA_WIDTH-1:0] mst_wdata;
    logic [NR_MASTERS-1:0][BE_WIDTH-1:0]   mst_be;
    logic [NR_MASTERS-1:0]                 mst_gnt;
    logic [NR_MASTERS-1:0]                 mst_r_valid;
    logic [DATA_WIDTH-1:0]                 mst_r_rdata;
    logic                                  mst_r_opc;

    // Shared slave port
    logic                  slv_req;
    logic [ADDR_WIDTH-1:0] slv_add;
    logic                  slv_wen;
    logic [DATA_WIDTH-1:0] slv_wdata;
    logic [BE_WIDTH-1:0]   slv_be;
    logic                  slv_gnt;
    logic                  slv_r_valid;
    logic [DATA_WIDTH-1:0] slv_r_rdata;
    logic                  slv_r_opc;

    modport slave (
        input  mst_req, mst_add, mst_wen, mst_wdata, mst_be,
        output mst_gnt, mst_r_valid, mst_r_rdata, mst_r_opc,
        output slv_req, slv_add, slv_wen, slv_wdata, slv_be,
        input  slv_gnt, slv_r_valid, slv_r_rdata, slv_r_opc
    );

    modport master (
        output mst_req, mst_add, mst_wen, mst_wdata, mst_be,
        input  mst_gnt, mst_r_valid, mst_r_rdata, mst_r_opc,
        input  slv_req, slv_add, slv_wen, slv_wdata, slv_be,
        output slv_gnt, slv_r_valid, slv_r_rdata, slv_r_opc
    );
endinterface

// File: rtl/soc_tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port among NR_MASTERS masters, with in-order response routing.
// Optional performance counters are built when SOC_TCDM_ARB_PERF_EN is defined.
module soc_tcdm_bank_arbiter #(
    parameter int unsigned NR_MASTERS      = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    soc_tcdm_bank_arbiter_if.slave      bus,
    input  logic                        perf_clr_i,
    output logic                        err_o,
    output logic [NR_MASTERS-1:0][31:0] perf_gnt_cnt_o,
    output logic [31:0]                 perf_stall_o
);
    localparam int unsigned IDX_W = $clog2(NR_MASTERS);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    idx_t rr_ptr_q, rr_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic err_q, err_d;
    idx_t fifo_mem_q [MAX_OUTSTANDING];
    idx_t fifo_mem_d [MAX_OUTSTANDING];

    idx_t winner;
    logic any_req;
    logic fifo_full;
    logic fifo_empty;
    logic handshake;
    logic pop;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + ptr_t'(1);
    endfunction

    assign any_req    = |bus.mst_req;
    assign fifo_full  = (count_q == cnt_t'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign pop        = bus.slv_r_valid && !fifo_empty;

    // Cyclic search: first requester at or after rr_ptr_q.
    always_comb begin
        logic found;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NR_MASTERS; k++) begin
            idx_t cand;
            cand = idx_t'((32'(rr_ptr_q) + k) % NR_MASTERS);
            if (!found && bus.mst_req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        bus.slv_req   = any_req && !fifo_full;
        bus.slv_add   = '0;
        bus.slv_wen   = 1'b0;
        bus.slv_wdata = '0;
        bus.slv_be    = '0;
        if (bus.slv_req) begin
            bus.slv_add   = bus.mst_add[winner];
            bus.slv_wen   = bus.mst_wen[winner];
            bus.slv_wdata = bus.mst_wdata[winner];
            bus.slv_be    = bus.mst_be[winner];
        end
        handshake   = bus.slv_req && bus.slv_gnt;
        bus.mst_gnt = '0;
        if (handshake) begin
            bus.mst_gnt[winner] = 1'b1;
        end
        bus.mst_r_valid = '0;
        if (pop) begin
            bus.mst_r_valid[fifo_mem_q[rd_ptr_q]] = 1'b1;
        end
    end

    assign bus.mst_r_rdata = bus.slv_r_rdata;
    assign bus.mst_r_opc   = bus.slv_r_opc;
    assign err_o           = err_q;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_mem_d = fifo_mem_q;
        if (handshake) begin
            rr_ptr_d             = (32'(winner) == NR_MASTERS - 1) ? '0 : winner + idx_t'(1);
            fifo_mem_d[wr_ptr_q] = winner;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + cnt_t'(handshake) - cnt_t'(pop);
        err_d   = err_q || (bus.slv_r_valid && fifo_empty);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // NOTE: routing storage is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        fifo_mem_q <= fifo_mem_d;
    end

`ifdef SOC_TCDM_ARB_PERF_EN
    logic [NR_MASTERS-1:0][31:0] perf_gnt_cnt_q, perf_gnt_cnt_d;
    logic [31:0]                 perf_stall_q, perf_stall_d;
    logic                        multi_req;
    logic                        stall_cycle;

    assign multi_req   = (bus.mst_req & (bus.mst_req - 1'b1)) != '0;
    assign stall_cycle = multi_req || (any_req && !handshake);

    // Saturating counters; a clear in the same cycle overrides any increment.
    always_comb begin
        perf_gnt_cnt_d = perf_gnt_cnt_q;
        perf_stall_d   = perf_stall_q;
        if (perf_clr_i) begin
            perf_gnt_cnt_d = '0;
            perf_stall_d   = '0;
        end else begin
            for (int unsigned i = 0; i < NR_MASTERS; i++) begin
                if (handshake && winner == idx_t'(i) && perf_gnt_cnt_q[i] != '1) begin
                    perf_gnt_cnt_d[i] = perf_gnt_cnt_q[i] + 32'd1;
                end
            end
            if (stall_cycle && perf_stall_q != '1) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_gnt_cnt_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_gnt_cnt_q <= perf_gnt_cnt_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_gnt_cnt_o = perf_gnt_cnt_q;
    assign perf_stall_o   = perf_stall_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr_i;
    assign perf_gnt_cnt_o  = '0;
    assign perf_stall_o    = '0;
`endif

endmodule

// File: tb/tb_soc_tcdm_bank_arbiter.sv
// Self-checking bench for soc_tcdm_bank_arbiter: vector table, directed corner sequences, and
// randomized traffic against a queue-based reference model (perf checks follow SOC_TCDM_ARB_PERF_EN).
`timescale 1ns/1ps
module tb_soc_tcdm_bank_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                perf_clr_i = 1'b0;
    logic                err_o;
    logic [NR-1:0][31:0] perf_gnt_cnt_o;
    logic [31:0]         perf_stall_o;

    soc_tcdm_bank_arbiter_if #(.NR_MASTERS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    soc_tcdm_bank_arbiter #(
        .NR_MASTERS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus), .perf_clr_i(perf_clr_i),
        .err_o(err_o), .perf_gnt_cnt_o(perf_gnt_cnt_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: round-robin start, issuer queue, sticky error, perf counters.
    int          m_rr;
    int          m_fifo[$];
    bit          m_err;
    longint      m_gcnt[NR];
    longint      m_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 32'h1C00_0000 + AW'(i * 16);
    endfunction

    task automatic fixed_fields();
        for (int i = 0; i < NR; i++) begin
            bus.mst_add[i]   = addr_of(i);
            bus.mst_wdata[i] = 32'hD000_0000 + DW'(i);
            bus.mst_be[i]    = BW'(i + 1);
        end
        bus.mst_wen = 4'b1110;
    endtask

    task automatic idle_inputs();
        bus.mst_req     = '0;
        bus.slv_gnt     = 1'b0;
        bus.slv_r_valid = 1'b0;
        bus.slv_r_rdata = '0;
        bus.slv_r_opc   = 1'b0;
        perf_clr_i      = 1'b0;
        fixed_fields();
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_fifo.delete();
        m_err = 1'b0;
        m_stall = 0;
        for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
    endtask

    // Called at a negedge with inputs applied; compares every output with the model, then advances the model.
    task automatic settle();
        int            win;
        int            nreq;
        bit            full;
        bit            e_req;
        bit            hs;
        logic [NR-1:0] e_gnt;
        logic [NR-1:0] e_rv;
        logic [AW-1:0] e_add;
        logic          e_wen;
        logic [DW-1:0] e_wdata;
        logic [BW-1:0] e_be;
        #1;
        nreq = $countones(bus.mst_req);
        full = (m_fifo.size() == MO);
        win  = -1;
        for (int k = 0; k < NR; k++) begin
            int c;
            c = (m_rr + k) % NR;
            if (win < 0 && bus.mst_req[c]) win = c;
        end
        e_req   = (nreq > 0) && !full;
        hs      = e_req && bus.slv_gnt;
        e_add   = '0;
        e_wen   = 1'b0;
        e_wdata = '0;
        e_be    = '0;
        if (e_req) begin
            e_add   = bus.mst_add[win];
            e_wen   = bus.mst_wen[win];
            e_wdata = bus.mst_wdata[win];
            e_be    = bus.mst_be[win];
        end
        e_gnt = '0;
        if (hs) e_gnt[win] = 1'b1;
        e_rv = '0;
        if (bus.slv_r_valid && m_fifo.size() > 0) e_rv[m_fifo[0]] = 1'b1;

        check("mst_gnt", 64'(bus.mst_gnt), 64'(e_gnt));
        check("slv_req", 64'(bus.slv_req), 64'(e_req));
        check("slv_add", 64'(bus.slv_add), 64'(e_add));
        check("slv_wen", 64'(bus.slv_wen), 64'(e_wen));
        check("slv_wdata", 64'(bus.slv_wdata), 64'(e_wdata));
        check("slv_be", 64'(bus.slv_be), 64'(e_be));
        check("mst_r_valid", 64'(bus.mst_r_valid), 64'(e_rv));
        check("mst_r_rdata", 64'(bus.mst_r_rdata), 64'(bus.slv_r_rdata));
        check("mst_r_opc", 64'(bus.mst_r_opc), 64'(bus.slv_r_opc));
        check("err_o", 64'(err_o), 64'(m_err));
        for (int i = 0; i < NR; i++) begin
`ifdef SOC_TCDM_ARB_PERF_EN
            check($sformatf("perf_gnt_cnt[%0d]", i), 64'(perf_gnt_cnt_o[i]), 64'(m_gcnt[i]));
`else
            check($sformatf("perf_gnt_cnt[%0d]", i), 64'(perf_gnt_cnt_o[i]), 64'd0);
`endif
        end
`ifdef SOC_TCDM_ARB_PERF_EN
        check("perf_stall", 64'(perf_stall_o), 64'(m_stall));
`else
        check("perf_stall", 64'(perf_stall_o), 64'd0);
`endif

        if (bus.slv_r_valid) begin
            if (m_fifo.size() > 0) void'(m_fifo.pop_front());
            else m_err = 1'b1;
        end
        if (perf_clr_i) begin
            for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
            m_stall = 0;
        end else begin
            if (hs && m_gcnt[win] < 64'hFFFF_FFFF) m_gcnt[win]++;
            if ((nreq >= 2 || (nreq >= 1 && !hs)) && m_stall < 64'hFFFF_FFFF) m_stall++;
        end
        if (hs) begin
            m_fifo.push_back(win);
            m_rr = (win + 1) % NR;
        end
    endtask

    task automatic advance();
        @(negedge clk_i);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        check("err_o in reset", 64'(err_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [NR-1:0] req;
        logic          gnt;
        logic          rv;
        logic [NR-1:0] e_gnt;
        logic          e_req;
        logic [AW-1:0] e_add;
        logic [NR-1:0] e_rv;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_errs;
        int gcount[NR];
        int pend[$];
        logic [NR-1:0] exp_oh;

        idle_inputs();
        model_reset();

        // Reset state: nothing pending, every output quiet.
        do_reset();
        settle();
        check("reset slv_req", 64'(bus.slv_req), 64'd0);
        check("reset slv_add", 64'(bus.slv_add), 64'd0);
        check("reset mst_gnt", 64'(bus.mst_gnt), 64'd0);
        advance();

        // Vector table applied from reset: rr starts at 0, routing FIFO empty.
        tbl[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, addr_of(0), 4'b0000};
        tbl[1]  = '{4'b1001, 1'b1, 1'b1, 4'b1000, 1'b1, addr_of(3), 4'b0001};
        tbl[2]  = '{4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, addr_of(1), 4'b0000};
        tbl[3]  = '{4'b0110, 1'b1, 1'b0, 4'b0010, 1'b1, addr_of(1), 4'b0000};
        tbl[4]  = '{4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,      4'b1000};
        tbl[5]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, addr_of(2), 4'b0010};
        tbl[6]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,      4'b0100};
        tbl[7]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, addr_of(3), 4'b0000};
        tbl[8]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, addr_of(0), 4'b0000};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,      4'b1000};
        tbl[10] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,      4'b0001};
        for (int v = 0; v < 11; v++) begin
            bus.mst_req     = tbl[v].req;
            bus.slv_gnt     = tbl[v].gnt;
            bus.slv_r_valid = tbl[v].rv;
            bus.slv_r_rdata = 32'h5000_0000 + DW'(v);
            settle();
            check($sformatf("tbl[%0d] gnt", v), 64'(bus.mst_gnt), 64'(tbl[v].e_gnt));
            check($sformatf("tbl[%0d] slv_req", v), 64'(bus.slv_req), 64'(tbl[v].e_req));
            check($sformatf("tbl[%0d] slv_add", v), 64'(bus.slv_add), 64'(tbl[v].e_add));
            check($sformatf("tbl[%0d] r_valid", v), 64'(bus.mst_r_valid), 64'(tbl[v].e_rv));
            advance();
        end

        // Single read from master 2, response one cycle later.
        do_reset();
        bus.mst_req     = 4'b0100;
        bus.mst_add[2]  = 32'h1C00_0010;
        bus.mst_wen[2]  = 1'b1;
        bus.slv_gnt     = 1'b1;
        settle();
        check("single gnt", 64'(bus.mst_gnt), 64'h4);
        check("single slv_add", 64'(bus.slv_add), 64'h1C00_0010);
        check("single slv_wen", 64'(bus.slv_wen), 64'd1);
        advance();
        bus.mst_req     = '0;
        bus.slv_gnt     = 1'b0;
        bus.slv_r_valid = 1'b1;
        bus.slv_r_rdata = 32'hCAFE_F00D;
        settle();
        check("single r_valid", 64'(bus.mst_r_valid), 64'h4);
        check("single rdata", 64'(bus.mst_r_rdata), 64'hCAFE_F00D);
        advance();

        // Full contention for 100 cycles with an always-granting, one-cycle-latency slave.
        do_reset();
        rr_errs = 0;
        for (int i = 0; i < NR; i++) gcount[i] = 0;
        for (int c = 0; c < 100; c++) begin
            bus.mst_req     = '1;
            bus.slv_gnt     = 1'b1;
            bus.slv_r_valid = (c > 0);
            settle();
            exp_oh = '0;
            exp_oh[c % NR] = 1'b1;
            if (bus.mst_gnt !== exp_oh) rr_errs++;
            for (int i = 0; i < NR; i++) if (bus.mst_gnt[i] === 1'b1) gcount[i]++;
            advance();
        end
        check("rr order errors", 64'(rr_errs), 64'd0);
        for (int i = 0; i < NR; i++) check($sformatf("rr grants[%0d]", i), 64'(gcount[i]), 64'd25);

        // Slave grants but answers 3 cycles late: two issues, then blocked (no bypass on pop).
        do_reset();
        pend.delete();
        for (int c = 0; c < 5; c++) begin
            bus.mst_req     = 4'b0001;
            bus.slv_gnt     = 1'b1;
            bus.slv_r_valid = (pend.size() > 0 && pend[0] == c);
            settle();
            if (bus.slv_r_valid) void'(pend.pop_front());
            check($sformatf("outst slv_req c%0d", c), 64'(bus.slv_req), (c == 2 || c == 3) ? 64'd0 : 64'd1);
            if (bus.mst_gnt[0] === 1'b1) pend.push_back(c + 3);
            advance();
        end
        idle_inputs();
        bus.slv_r_valid = 1'b1;
        repeat (2) cycle();

        // Slave stall with masters 1 and 3 requesting: winner pinned to 1, then 3.
        do_reset();
        bus.mst_req = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("stall add c%0d", c), 64'(bus.slv_add), 64'(addr_of(1)));
            check($sformatf("stall gnt c%0d", c), 64'(bus.mst_gnt), 64'd0);
            advance();
        end
        bus.slv_gnt = 1'b1;
        settle();
        check("stall release gnt", 64'(bus.mst_gnt), 64'h2);
        advance();
        settle();
        check("stall next gnt", 64'(bus.mst_gnt), 64'h8);
        advance();

        // Unsolicited response: no routing, sticky error until reset.
        do_reset();
        bus.slv_r_valid = 1'b1;
        settle();
        check("unsolicited r_valid", 64'(bus.mst_r_valid), 64'd0);
        advance();
        bus.slv_r_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("err sticky c%0d", c), 64'(err_o), 64'd1);
            advance();
        end

`ifdef SOC_TCDM_ARB_PERF_EN
        // Ten handshakes of master 0, clear, then saturation from a preload.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            bus.mst_req     = 4'b0001;
            bus.slv_gnt     = 1'b1;
            bus.slv_r_valid = (c > 0);
            cycle();
        end
        idle_inputs();
        bus.slv_r_valid = 1'b1;
        settle();
        check("perf cnt 10", 64'(perf_gnt_cnt_o[0]), 64'd10);
        advance();
        bus.slv_r_valid = 1'b0;
        perf_clr_i = 1'b1;
        cycle();
        perf_clr_i = 1'b0;
        settle();
        check("perf cnt cleared", 64'(perf_gnt_cnt_o[0]), 64'd0);
        advance();
        force dut.perf_gnt_cnt_q[0] = 32'hFFFF_FFFE;
        #1;
        release dut.perf_gnt_cnt_q[0];
        m_gcnt[0] = 64'hFFFF_FFFE;
        for (int c = 0; c < 3; c++) begin
            bus.mst_req     = 4'b0001;
            bus.slv_gnt     = 1'b1;
            bus.slv_r_valid = (c > 0);
            cycle();
        end
        idle_inputs();
        settle();
        check("perf cnt saturated", 64'(perf_gnt_cnt_o[0]), 64'hFFFF_FFFF);
        advance();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.mst_req = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                bus.mst_add[i]   = $urandom;
                bus.mst_wdata[i] = $urandom;
                bus.mst_be[i]    = BW'($urandom);
            end
            bus.mst_wen     = NR'($urandom);
            bus.slv_gnt     = ($urandom_range(0, 3) != 0);
            bus.slv_r_valid = (m_fifo.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.slv_r_rdata = $urandom;
            bus.slv_r_opc   = 1'($urandom);
            perf_clr_i      = ($urandom_range(0, 49) == 0);
            cycle();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
